// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game core.
package pong_pkg;

   // Game phase: ball held before a serve, rally in progress, game finished.
   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2
   } state_t;

   // Centre net geometry: width in pixels and dash period in lines.
   localparam int NET_W    = 2;
   localparam int NET_DASH = 16;

   // One spare bit above the 10-bit screen coordinates so that steps past
   // either screen edge are visible as overflow instead of wrapping.
   typedef logic [10:0] pos_t;

   function automatic pos_t to_pos(input logic [9:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Button-driven paddle: one step per frame tick, clamped to the screen.
module pong_paddle_ctrl
   import pong_pkg::*;
#(
   parameter int V_ACTIVE     = 480,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_SPEED = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       up,
   input  logic       dn,
   input  logic       tick,
   input  logic       hold,
   input  logic       recenter,
   output logic [9:0] y
);

   localparam pos_t Y_MAX = pos_t'(V_ACTIVE - PADDLE_H);
   localparam pos_t Y_MID = pos_t'((V_ACTIVE - PADDLE_H) / 2);

   pos_t y_cur, y_up, y_dn, y_next;

   assign y_cur = to_pos(y);
   assign y_up  = y_cur - pos_t'(PADDLE_SPEED);
   assign y_dn  = y_cur + pos_t'(PADDLE_SPEED);

   // Candidate position for this frame; an upward step below zero sets the spare bit.
   always_comb begin
      // NOTE: default assignment first so every path drives y_next and no latch is inferred.
      y_next = y_cur;
      if (up && !dn) begin
         y_next = y_up[10] ? '0 : y_up;
      end else if (dn && !up) begin
         y_next = (y_dn > Y_MAX) ? Y_MAX : y_dn;
      end
   end

   // Position register: recentre on restart, freeze while held, else step.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      if (!rst_n) begin
         y <= Y_MID[9:0];
      end else if (tick) begin
         if (recenter) begin
            y <= Y_MID[9:0];
         end else if (!hold) begin
            y <= y_next[9:0];
         end
      end
   end

endmodule

// File: rtl/pong_engine.sv
// Two-player pong core: frame tick, ball physics, scoring, serve/over FSM
// and registered pixel layers for the colour mux.
module pong_engine
   import pong_pkg::*;
#(
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int PADDLE_H      = 64,
   parameter int PADDLE_W      = 8,
   parameter int PADDLE_MARGIN = 16,
   parameter int BALL_SIZE     = 8,
   parameter int BALL_SPEED    = 2,
   parameter int PADDLE_SPEED  = 4,
   parameter int SCORE_MAX     = 9,
   parameter int SERVE_FRAMES  = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       de,
   input  logic       p1_up,
   input  logic       p1_dn,
   input  logic       p2_up,
   input  logic       p2_dn,
   input  logic       start,
   output logic       pix_ball,
   output logic       pix_paddle,
   output logic       pix_net,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over
);

   localparam int   CNT_W   = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam pos_t BX_MID  = pos_t'((H_ACTIVE - BALL_SIZE) / 2);
   localparam pos_t BY_MID  = pos_t'((V_ACTIVE - BALL_SIZE) / 2);
   localparam pos_t BX_MAX  = pos_t'(H_ACTIVE - BALL_SIZE);
   localparam pos_t BY_MAX  = pos_t'(V_ACTIVE - BALL_SIZE);
   localparam pos_t BALL    = pos_t'(BALL_SIZE);
   localparam pos_t SPD     = pos_t'(BALL_SPEED);
   localparam pos_t PH      = pos_t'(PADDLE_H);
   localparam pos_t P1_X    = pos_t'(PADDLE_MARGIN);
   localparam pos_t P1_FACE = pos_t'(PADDLE_MARGIN + PADDLE_W);
   localparam pos_t P2_X    = pos_t'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W);
   localparam pos_t P2_END  = pos_t'(H_ACTIVE - PADDLE_MARGIN);
   localparam pos_t P2_FACE = pos_t'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
   localparam pos_t NET_X   = pos_t'(H_ACTIVE / 2 - NET_W / 2);
   localparam pos_t NET_END = pos_t'(H_ACTIVE / 2 - NET_W / 2 + NET_W);

   state_t           state, state_next;
   logic             vsync_q, frame_tick;
   logic [9:0]       ball_x, ball_y, paddle1_y, paddle2_y;
   logic             dx_neg, dy_neg, ndy_neg;
   logic [CNT_W-1:0] serve_cnt;
   pos_t             bx, by, p1, p2, nx, ny_raw, ny, h, v, v_dash;
   logic             wall_top, wall_bot, hit1, hit2, miss1, miss2;
   logic             point1, point2, win, serve_done, in_over, restart;
   logic             in_ball, in_pad, in_net;

   // Previous vsync level; the falling edge marks the start of a frame.
   always_ff @(posedge clk) begin
      if (!rst_n) vsync_q <= 1'b0;
      else        vsync_q <= vsync;
   end
   assign frame_tick = vsync_q & ~vsync;

   assign in_over = (state == OVER);
   assign restart = in_over && start;

   pong_paddle_ctrl #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED))
      u_paddle1 (.clk(clk), .rst_n(rst_n), .up(p1_up), .dn(p1_dn), .tick(frame_tick),
                 .hold(in_over), .recenter(restart), .y(paddle1_y));

   pong_paddle_ctrl #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED))
      u_paddle2 (.clk(clk), .rst_n(rst_n), .up(p2_up), .dn(p2_dn), .tick(frame_tick),
                 .hold(in_over), .recenter(restart), .y(paddle2_y));

   assign bx     = to_pos(ball_x);
   assign by     = to_pos(ball_y);
   assign p1     = to_pos(paddle1_y);
   assign p2     = to_pos(paddle2_y);
   assign nx     = dx_neg ? bx - SPD : bx + SPD;
   assign ny_raw = dy_neg ? by - SPD : by + SPD;

   assign wall_top = ny_raw[10] || (ny_raw == '0);
   assign wall_bot = !ny_raw[10] && (ny_raw >= BY_MAX);

   // Vertical step with wall clamp and bounce.
   always_comb begin
      ny      = ny_raw;
      ndy_neg = dy_neg;
      if (wall_top) begin
         ny      = '0;
         ndy_neg = 1'b0;
      end else if (wall_bot) begin
         ny      = BY_MAX;
         ndy_neg = 1'b1;
      end
   end

   // Paddle contact uses the stepped ball against the paddles as they stood before this frame.
   assign hit1  = dx_neg && !nx[10] && (nx < P1_FACE) && (nx + BALL > P1_X)
                  && (ny < p1 + PH) && (ny + BALL > p1);
   assign hit2  = !dx_neg && (nx < P2_END) && (nx + BALL > P2_X)
                  && (ny < p2 + PH) && (ny + BALL > p2);
   assign miss1 = dx_neg && (nx[10] || (nx == '0));
   assign miss2 = !dx_neg && (nx >= BX_MAX);

   assign point1     = (state == PLAY) && miss2 && !hit2;
   assign point2     = (state == PLAY) && miss1 && !hit1;
   assign win        = (point1 && (score1 == 4'(SCORE_MAX - 1)))
                    || (point2 && (score2 == 4'(SCORE_MAX - 1)));
   assign serve_done = (state == SERVE) && (serve_cnt == CNT_W'(SERVE_FRAMES - 1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= SERVE;
      else        state <= state_next;
   end

   // FSM next state, evaluated only on frame ticks.
   always_comb begin
      state_next = state;
      if (frame_tick) begin
         case (state)
            SERVE:   if (serve_done) state_next = PLAY;
            PLAY:    if (point1 || point2) state_next = win ? OVER : SERVE;
            OVER:    if (start) state_next = SERVE;
            default: state_next = SERVE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      game_over = in_over;
   end

   // Ball, direction, serve counter and scores, all advanced on frame ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ball_x    <= BX_MID[9:0];
         ball_y    <= BY_MID[9:0];
         dx_neg    <= 1'b0;
         dy_neg    <= 1'b0;
         serve_cnt <= '0;
         score1    <= '0;
         score2    <= '0;
      end else if (frame_tick) begin
         case (state)
            SERVE: begin
               if (serve_done) begin
                  // Ball sits at centre, so the normal step is the launch step.
                  serve_cnt <= '0;
                  ball_x    <= nx[9:0];
                  ball_y    <= ny[9:0];
                  dy_neg    <= ndy_neg;
               end else begin
                  serve_cnt <= serve_cnt + CNT_W'(1);
               end
            end
            PLAY: begin
               ball_y <= ny[9:0];
               dy_neg <= ndy_neg;
               if (hit1) begin
                  ball_x <= P1_FACE[9:0];
                  dx_neg <= 1'b0;
               end else if (hit2) begin
                  ball_x <= P2_FACE[9:0];
                  dx_neg <= 1'b1;
               end else if (point2) begin
                  ball_x <= BX_MID[9:0];
                  ball_y <= BY_MID[9:0];
                  dx_neg <= 1'b1;
                  score2 <= score2 + 4'd1;
               end else if (point1) begin
                  ball_x <= BX_MID[9:0];
                  ball_y <= BY_MID[9:0];
                  dx_neg <= 1'b0;
                  score1 <= score1 + 4'd1;
               end else begin
                  ball_x <= nx[9:0];
               end
            end
            OVER: begin
               if (start) begin
                  score1 <= '0;
                  score2 <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign h      = to_pos(hpos);
   assign v      = to_pos(vpos);
   assign v_dash = v / pos_t'(NET_DASH);

   assign in_ball = !in_over && (h >= bx) && (h < bx + BALL) && (v >= by) && (v < by + BALL);
   assign in_pad  = ((h >= P1_X) && (h < P1_FACE) && (v >= p1) && (v < p1 + PH))
                 || ((h >= P2_X) && (h < P2_END)  && (v >= p2) && (v < p2 + PH));
   assign in_net  = (h >= NET_X) && (h < NET_END) && !v_dash[0];

   // Pixel layers registered once, gated by display enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_ball   <= 1'b0;
         pix_paddle <= 1'b0;
         pix_net    <= 1'b0;
      end else begin
         pix_ball   <= de && in_ball;
         pix_paddle <= de && in_pad;
         pix_net    <= de && in_net;
      end
   end

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: reset/pixel vector table, directed
// serve/clamp/miss/hit/game-over sequences and randomised play against a
// frame-level reference model.
module tb_pong_engine;

   localparam int CX = 316, CY = 236, PMID = 208;
   localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;

   logic       clk = 1'b0;
   logic       rst_n, vsync, de, p1_up, p1_dn, p2_up, p2_dn, start;
   logic [9:0] hpos, vpos;
   logic       pix_ball, pix_paddle, pix_net, game_over;
   logic [3:0] score1, score2;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: signed positions, +1/-1 directions.
   int m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_mode, m_cnt;
   bit m_hit_left;

   typedef struct {
      int x; int y; bit d;
      bit b; bit p; bit n;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   pong_engine dut (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .hpos(hpos), .vpos(vpos), .de(de),
      .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .start(start),
      .pix_ball(pix_ball), .pix_paddle(pix_paddle), .pix_net(pix_net),
      .score1(score1), .score2(score2), .game_over(game_over)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int clamp(input int val, input int lo, input int hi);
      return (val < lo) ? lo : (val > hi) ? hi : val;
   endfunction

   function automatic int pdelta(input logic up, input logic dn);
      if (up && !dn) return -4;
      if (dn && !up) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
      m_p1 = PMID; m_p2 = PMID; m_s1 = 0; m_s2 = 0;
      m_mode = M_SERVE; m_cnt = 0; m_hit_left = 0;
   endtask

   // One frame of game rules, using the buttons currently driven.
   task automatic model_step();
      int o1, o2, nx, ny;
      bit hit;
      o1 = m_p1; o2 = m_p2; m_hit_left = 0;
      if (m_mode == M_OVER) begin
         if (start) begin
            m_s1 = 0; m_s2 = 0; m_p1 = PMID; m_p2 = PMID; m_mode = M_SERVE;
         end
      end else begin
         m_p1 = clamp(m_p1 + pdelta(p1_up, p1_dn), 0, 416);
         m_p2 = clamp(m_p2 + pdelta(p2_up, p2_dn), 0, 416);
         if (m_mode == M_SERVE) begin
            if (m_cnt == 59) begin
               m_cnt = 0; m_mode = M_PLAY;
               m_bx += 2 * m_dx; m_by += 2 * m_dy;
            end else begin
               m_cnt++;
            end
         end else begin
            nx = m_bx + 2 * m_dx;
            ny = m_by + 2 * m_dy;
            if (ny <= 0) begin ny = 0; m_dy = 1; end
            else if (ny >= 472) begin ny = 472; m_dy = -1; end
            if (m_dx < 0) hit = (nx < 24) && (nx + 8 > 16) && (ny < o1 + 64) && (ny + 8 > o1);
            else          hit = (nx < 624) && (nx + 8 > 616) && (ny < o2 + 64) && (ny + 8 > o2);
            m_by = ny;
            if (hit) begin
               if (m_dx < 0) begin m_bx = 24; m_hit_left = 1; end
               else m_bx = 608;
               m_dx = -m_dx;
            end else if (m_dx < 0 && nx <= 0) begin
               m_s2++; m_bx = CX; m_by = CY; m_dx = -1;
               m_mode = (m_s2 == 9) ? M_OVER : M_SERVE;
            end else if (m_dx > 0 && nx >= 632) begin
               m_s1++; m_bx = CX; m_by = CY; m_dx = 1;
               m_mode = (m_s1 == 9) ? M_OVER : M_SERVE;
            end else begin
               m_bx = nx;
            end
         end
      end
   endtask

   function automatic bit exp_ball(input int x, input int y);
      return (m_mode != M_OVER) && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8;
   endfunction

   function automatic bit exp_pad(input int x, input int y);
      return (x >= 16 && x < 24 && y >= m_p1 && y < m_p1 + 64)
          || (x >= 616 && x < 624 && y >= m_p2 && y < m_p2 + 64);
   endfunction

   function automatic bit exp_net(input int x, input int y);
      return (x == 319 || x == 320) && ((y / 16) % 2 == 0);
   endfunction

   // One frame: vsync falling edge seen at one posedge, then released.
   task automatic do_tick();
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
      model_step();
      check("score1", score1, m_s1);
      check("score2", score2, m_s2);
      check("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
   endtask

   // Present a pixel and wait for its registered result.
   task automatic sample(input int x, input int y, input bit d);
      @(negedge clk);
      hpos = 10'(x); vpos = 10'(y); de = d;
      @(negedge clk);
   endtask

   task automatic model_probe(input int x, input int y);
      sample(x, y, 1'b1);
      check($sformatf("ball(%0d,%0d)", x, y), pix_ball, exp_ball(x, y));
      check($sformatf("paddle(%0d,%0d)", x, y), pix_paddle, exp_pad(x, y));
      check($sformatf("net(%0d,%0d)", x, y), pix_net, exp_net(x, y));
   endtask

   task automatic check_ball_at(input string name, input int x, input int y);
      sample(x, y, 1'b1);         check({name, "_tl"}, pix_ball, 1);
      sample(x + 7, y + 7, 1'b1); check({name, "_br"}, pix_ball, 1);
      sample(x - 1, y, 1'b1);     check({name, "_left"}, pix_ball, 0);
      sample(x + 8, y, 1'b1);     check({name, "_right"}, pix_ball, 0);
      sample(x, y - 1, 1'b1);     check({name, "_above"}, pix_ball, 0);
      sample(x, y + 8, 1'b1);     check({name, "_below"}, pix_ball, 0);
   endtask

   task automatic check_p1_top(input string name, input int y);
      sample(20, y, 1'b1);      check({name, "_top"}, pix_paddle, 1);
      sample(20, y + 63, 1'b1); check({name, "_bottom"}, pix_paddle, 1);
      sample(20, y + 64, 1'b1); check({name, "_below"}, pix_paddle, 0);
      if (y > 0) begin
         sample(20, y - 1, 1'b1); check({name, "_above"}, pix_paddle, 0);
      end
   endtask

   // Move a paddle toward (track) or away from (dodge) the ball.
   task automatic steer(input int who, input bit track);
      int pc, bc;
      bit u, d;
      pc = ((who == 1) ? m_p1 : m_p2) + 32;
      bc = m_by + 4;
      if (track) begin u = (pc > bc + 2); d = (pc < bc - 2); end
      else       begin u = (bc >= 240);   d = (bc < 240);    end
      if (who == 1) begin p1_up = u; p1_dn = d; end
      else          begin p2_up = u; p2_dn = d; end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int old_s2;
      bit hit_checked;

      rst_n = 1'b0; vsync = 1'b1; de = 1'b0; hpos = '0; vpos = '0;
      p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; start = 0;
      model_reset();

      // Reset held for two clocks.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_score1", score1, 0);
      check("rst_score2", score2, 0);
      check("rst_game_over", game_over, 0);
      check("rst_pix_ball", pix_ball, 0);
      check("rst_pix_paddle", pix_paddle, 0);
      check("rst_pix_net", pix_net, 0);
      rst_n = 1'b1;

      // Pixel vectors against the reset geometry.
      vecs.push_back('{316, 236, 1, 1, 0, 0});
      vecs.push_back('{323, 243, 1, 1, 0, 0});
      vecs.push_back('{315, 236, 1, 0, 0, 0});
      vecs.push_back('{324, 243, 1, 0, 0, 0});
      vecs.push_back('{316, 244, 1, 0, 0, 0});
      vecs.push_back('{319, 236, 1, 1, 0, 1});
      vecs.push_back('{16,  208, 1, 0, 1, 0});
      vecs.push_back('{23,  271, 1, 0, 1, 0});
      vecs.push_back('{16,  207, 1, 0, 0, 0});
      vecs.push_back('{24,  240, 1, 0, 0, 0});
      vecs.push_back('{15,  240, 1, 0, 0, 0});
      vecs.push_back('{623, 240, 1, 0, 1, 0});
      vecs.push_back('{616, 272, 1, 0, 0, 0});
      vecs.push_back('{320, 0,   1, 0, 0, 1});
      vecs.push_back('{318, 0,   1, 0, 0, 0});
      vecs.push_back('{321, 0,   1, 0, 0, 0});
      vecs.push_back('{320, 16,  1, 0, 0, 0});
      vecs.push_back('{319, 47,  1, 0, 0, 1});
      vecs.push_back('{320, 0,   0, 0, 0, 0});
      vecs.push_back('{316, 236, 0, 0, 0, 0});
      foreach (vecs[i]) begin
         sample(vecs[i].x, vecs[i].y, vecs[i].d);
         check($sformatf("vec%0d_ball", i), pix_ball, vecs[i].b);
         check($sformatf("vec%0d_paddle", i), pix_paddle, vecs[i].p);
         check($sformatf("vec%0d_net", i), pix_net, vecs[i].n);
      end

      // Serve delay: 59 frames held, launch on the 60th.
      repeat (59) do_tick();
      check_ball_at("serve_hold", 316, 236);
      do_tick();
      check_ball_at("serve_launch", 318, 238);

      // Paddle clamp at the top, then both buttons hold.
      p1_up = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         do_tick();
         if (i == 51) check_p1_top("clamp51", 4);
         if (i == 52) check_p1_top("clamp52", 0);
      end
      check_p1_top("clamp60", 0);
      p1_dn = 1'b1;
      do_tick();
      check_p1_top("both_hold", 0);
      p1_up = 1'b0; p1_dn = 1'b0;

      // Randomised play against the model; start must be ignored here.
      for (int i = 0; i < 300; i++) begin
         p1_up = 1'($urandom_range(0, 1)); p1_dn = 1'($urandom_range(0, 1));
         p2_up = 1'($urandom_range(0, 1)); p2_dn = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 7) == 0);
         do_tick();
         if (i % 4 == 0) begin
            model_probe(m_bx, m_by);
            model_probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
         end
      end
      start = 1'b0;

      // Player 1 dodges, player 2 tracks: expect a left-side miss.
      old_s2 = m_s2;
      for (int t = 0; t < 1500 && m_s2 == old_s2; t++) begin
         steer(1, 1'b0);
         steer(2, 1'b1);
         do_tick();
         if (t % 4 == 0) model_probe(m_bx, m_by);
      end
      check("miss_score2", score2, old_s2 + 1);
      check_ball_at("miss_recentred", 316, 236);
      p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
      repeat (60) do_tick();
      check_ball_at("serve_toward_loser", 314, m_by);

      // Player 1 tracks, player 2 dodges until the game ends.
      hit_checked = 1'b0;
      for (int t = 0; t < 6000 && m_mode != M_OVER; t++) begin
         steer(1, 1'b1);
         steer(2, 1'b0);
         do_tick();
         if (m_hit_left && !hit_checked) begin
            check_ball_at("left_hit_snap", 24, m_by);
            hit_checked = 1'b1;
         end
         if (t % 4 == 0) model_probe(m_bx, m_by);
      end
      p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
      check("over_flag", game_over, 1);
      check("over_score1", score1, 9);
      sample(316, 236, 1'b1);
      check("over_ball_hidden", pix_ball, 0);

      // Restart only on a tick with start high.
      do_tick();
      check("over_hold", game_over, 1);
      start = 1'b1;
      do_tick();
      start = 1'b0;
      check("restart_score1", score1, 0);
      check("restart_score2", score2, 0);
      check("restart_over", game_over, 0);
      check_ball_at("restart_ball", 316, 236);
      sample(20, 208, 1'b1);  check("restart_p1_top", pix_paddle, 1);
      sample(20, 207, 1'b1);  check("restart_p1_above", pix_paddle, 0);
      sample(620, 271, 1'b1); check("restart_p2_bottom", pix_paddle, 1);
      sample(620, 272, 1'b1); check("restart_p2_below", pix_paddle, 0);

      // Net pixel with and without display enable.
      sample(320, 0, 1'b1);
      check("net_on", pix_net, 1);
      sample(320, 0, 1'b0);
      check("net_de_off", pix_net, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
